// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM encoding, default width.
package alu_pkg;

  localparam int DEF_WIDTH = 32;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_XOR  = 4'd2;
  localparam logic [3:0] OP_SLT  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_NAND = 4'd5;
  localparam logic [3:0] OP_NOR  = 4'd6;
  localparam logic [3:0] OP_OR   = 4'd7;
  localparam logic [3:0] OP_MUL  = 4'd8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_mul.sv
// Iterative shift-add unsigned multiplier: one partial product per cycle for
// WIDTH cycles after start. done is high during the cycle whose closing edge
// performs the final iteration, so the full product is in product right after it.
module seq_mul #(
  parameter int WIDTH = alu_pkg::DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic               running;

  assign done = running && (cnt == CW'(1));

  // Load operands on start, then add/shift one multiplier bit per cycle; product holds afterwards
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand   <= '0;
      mplier  <= '0;
      product <= '0;
      cnt     <= '0;
      running <= 1'b0;
    end else if (start) begin
      mcand   <= {{WIDTH{1'b0}}, a};
      mplier  <= b;
      product <= '0;
      cnt     <= CW'(WIDTH);
      running <= 1'b1;
    end else if (running) begin
      if (mplier[0]) begin
        product <= product + mcand;
      end
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        running <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready handshake. Single-cycle ops finish one cycle
// after acceptance; MUL iterates in seq_mul for WIDTH cycles. Results are held
// in DONE until the consumer takes them.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             cout,
  output logic             busy
);

  localparam int MSB = WIDTH - 1;

  state_t               state, state_nxt;
  logic                 accept, mul_start, mul_done, mul_sel;
  logic [2*WIDTH-1:0]   product;
  logic [3:0]           op_q;
  logic [WIDTH-1:0]     res_q;
  logic                 ovf_q, cout_q;

  // Single-cycle operations; returns {cout, overflow, result}
  function automatic logic [WIDTH+1:0] alu_eval(input logic [3:0] f,
                                                input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
    logic [WIDTH:0]          sum;
    logic signed [WIDTH-1:0] sx, sy;
    logic [WIDTH-1:0]        r;
    logic                    v, c;
    sx  = x;
    sy  = y;
    sum = '0;
    r   = '0;
    v   = 1'b0;
    c   = 1'b0;
    case (f)
      OP_ADD: begin
        sum = {1'b0, x} + {1'b0, y};
        r   = sum[MSB:0];
        c   = sum[WIDTH];
        v   = (x[MSB] == y[MSB]) && (r[MSB] != x[MSB]);
      end
      OP_SUB: begin
        sum = {1'b0, x} + {1'b0, ~y} + (WIDTH+1)'(1);
        r   = sum[MSB:0];
        c   = sum[WIDTH];
        v   = (x[MSB] != y[MSB]) && (r[MSB] != x[MSB]);
      end
      OP_XOR:  r = x ^ y;
      // Direct signed compare, so an overflowing a-b cannot flip the answer
      OP_SLT:  r = {{(WIDTH-1){1'b0}}, (sx < sy)};
      OP_AND:  r = x & y;
      OP_NAND: r = ~(x & y);
      OP_NOR:  r = ~(x | y);
      OP_OR:   r = x | y;
      default: r = '0;
    endcase
    return {c, v, r};
  endfunction

  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (op == OP_MUL);

  seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (product)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; requests outside IDLE never reach accept
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept)    state_nxt = (op == OP_MUL) ? S_MUL : S_DONE;
      S_MUL:  if (mul_done)  state_nxt = S_DONE;
      S_DONE: if (out_ready) state_nxt = S_IDLE;
      default:               state_nxt = S_IDLE;
    endcase
  end

  // Handshake and status outputs decoded from state
  always_comb begin
    in_ready  = (state == S_IDLE);
    busy      = (state == S_MUL);
    out_valid = (state == S_DONE);
  end

  // Capture op and the single-cycle result at acceptance; MUL results come from seq_mul
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= '0;
      res_q  <= '0;
      ovf_q  <= 1'b0;
      cout_q <= 1'b0;
    end else if (accept) begin
      op_q <= op;
      if (op == OP_MUL) {cout_q, ovf_q, res_q} <= '0;
      else              {cout_q, ovf_q, res_q} <= alu_eval(op, a, b);
    end
  end

  // Zero is only meaningful alongside a presented result, which also keeps it low in reset
  assign mul_sel  = (state == S_DONE) && (op_q == OP_MUL);
  assign result   = mul_sel ? product[MSB:0] : res_q;
  assign overflow = mul_sel ? (|product[2*WIDTH-1:WIDTH]) : ovf_q;
  assign cout     = mul_sel ? 1'b0 : cout_q;
  assign zero     = out_valid && (result == '0);

endmodule
